// File: rtl/ccff_chain_loader_pkg.sv
// rtl/ccff_chain_loader_pkg.sv - shared types, constants and CRC step for the configuration chain loader
// Holds the loader state encoding and the bit-serial CRC-16-CCITT update.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // MSB-first register: feedback is the outgoing MSB xor the incoming bit.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
      logic fb;
      fb = crc[15] ^ bit_in;
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/ccff_chain_loader_crc16_serial.sv
// rtl/ccff_chain_loader_crc16_serial.sv - one-bit-per-cycle CRC-16-CCITT accumulator
// init has priority over en so a new pass always starts from the seed value.
module crc16_serial
   import ccff_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic [15:0] crc_d;
   logic [15:0] crc_q;

   always_comb begin
      crc_d = crc_q;
      if (init) begin
         crc_d = CRC16_INIT;
      end else if (en) begin
         crc_d = crc16_step(crc_q, bit_in);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= CRC16_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises bitstream words into the ccff_head -> ccff_tail configuration chain
// Gates the chain clock, counts shifted bits and keeps CRCs of bits sent and bits returned.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 1024,
   parameter int WORD_W    = 32
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic              abort,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WORD_W-1:0] cfg_data,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_clk_en,
   output logic              busy,
   output logic              done,
   output logic [15:0]       crc_in,
   output logic [15:0]       crc_out
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int REM_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);
   localparam logic [REM_W-1:0] REM_FULL = REM_W'(WORD_W - 1);

   state_e              state_d, state_q;
   logic [CNT_W-1:0]    bit_cnt_d, bit_cnt_q;
   logic [WORD_W-1:0]   shreg_d, shreg_q;
   logic [REM_W-1:0]    rem_d, rem_q;
   logic                head_d, head_q;
   logic                start_ok;

   assign start_ok = start & ~abort & ((state_q == IDLE) | (state_q == DONE));

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      rem_d        = rem_q;
      head_d       = head_q;
      // abort gates both handshake and chain clock in the cycle it is seen
      cfg_ready    = (state_q == FETCH) & ~abort;
      chain_clk_en = (state_q == SHIFT) & ~abort;

      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_ok) begin
                  state_d   = FETCH;
                  bit_cnt_d = '0;
               end
            end
            FETCH: begin
               if (cfg_valid) begin
                  head_d  = cfg_data[0];
                  shreg_d = cfg_data >> 1;
                  rem_d   = REM_FULL;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               // head holds its last value through the inter-word FETCH gap
               if (bit_cnt_q == LAST_IDX) begin
                  state_d = DONE;
               end else if (rem_q == '0) begin
                  state_d = FETCH;
               end else begin
                  head_d  = shreg_q[0];
                  shreg_d = shreg_q >> 1;
                  rem_d   = rem_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         rem_q     <= '0;
         head_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         rem_q     <= rem_d;
         head_q    <= head_d;
      end
   end

   assign ccff_head = head_q;
   assign busy      = (state_q == FETCH) | (state_q == SHIFT);
   assign done      = (state_q == DONE);

   crc16_serial u_crc_in (
      .clk    (prog_clk),
      .rst_n  (prog_reset),
      .init   (start_ok),
      .en     (chain_clk_en),
      .bit_in (head_q),
      .crc    (crc_in)
   );

   crc16_serial u_crc_out (
      .clk    (prog_clk),
      .rst_n  (prog_reset),
      .init   (start_ok),
      .en     (chain_clk_en),
      .bit_in (ccff_tail),
      .crc    (crc_out)
   );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader with 64-bit and 40-bit chains
// Chain models are plain shift registers clocked through chain_clk_en.
module tb_ccff_chain_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] data = '0;
   bit          sel = 1'b0;

   logic        start_a, abort_a, start_b, abort_b;
   logic        ready_a, head_a, en_a, busy_a, done_a;
   logic        ready_b, head_b, en_b, busy_b, done_b;
   logic [15:0] crcin_a, crcout_a, crcin_b, crcout_b;
   logic [63:0] chain_a = '0;
   logic [39:0] chain_b = '0;

   logic        ready, head, en, busy, done;
   logic [15:0] crcin, crcout;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   assign start_a = start & ~sel;
   assign abort_a = abort & ~sel;
   assign start_b = start & sel;
   assign abort_b = abort & sel;

   ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(32)) dut (
      .prog_clk(clk), .prog_reset(rst_n), .start(start_a), .abort(abort_a),
      .cfg_valid(valid), .cfg_ready(ready_a), .cfg_data(data),
      .ccff_head(head_a), .ccff_tail(chain_a[0]), .chain_clk_en(en_a),
      .busy(busy_a), .done(done_a), .crc_in(crcin_a), .crc_out(crcout_a)
   );

   ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut40 (
      .prog_clk(clk), .prog_reset(rst_n), .start(start_b), .abort(abort_b),
      .cfg_valid(valid), .cfg_ready(ready_b), .cfg_data(data),
      .ccff_head(head_b), .ccff_tail(chain_b[0]), .chain_clk_en(en_b),
      .busy(busy_b), .done(done_b), .crc_in(crcin_b), .crc_out(crcout_b)
   );

   always @(posedge clk) begin
      if (en_a) chain_a <= {head_a, chain_a[63:1]};
      if (en_b) chain_b <= {head_b, chain_b[39:1]};
   end

   assign ready  = sel ? ready_b  : ready_a;
   assign head   = sel ? head_b   : head_a;
   assign en     = sel ? en_b     : en_a;
   assign busy   = sel ? busy_b   : busy_a;
   assign done   = sel ? done_b   : done_a;
   assign crcin  = sel ? crcin_b  : crcin_a;
   assign crcout = sel ? crcout_b : crcout_a;

   // pass results
   bit          exp_bits[$];
   bit          old_bits[$];
   logic [15:0] exp_crc_in, exp_crc_out;
   int          en_cnt, fetch_cnt, hs_cnt, head_err, bubble_err, last_en_cyc, done_cyc;
   bit          timed_out;
   logic        abort_en, post_busy, post_done, post_ready;

   function automatic logic [15:0] crc16_of(input bit b[$], input int n);
      logic [15:0] r;
      r = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         r = {r[14:0], 1'b0} ^ (((r[15] ^ b[i]) != 1'b0) ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_pass(input logic [31:0] w0, input logic [31:0] w1,
                           input bit throttle, input int abort_at);
      int len, cyc, fed, nbits;
      bit aborted;
      len = sel ? 40 : 64;
      exp_bits.delete();
      old_bits.delete();
      for (int i = 0; i < len; i++) begin
         exp_bits.push_back(i < 32 ? w0[i] : w1[i-32]);
         old_bits.push_back(sel ? chain_b[i] : chain_a[i]);
      end
      nbits = (abort_at >= 0 && abort_at < len) ? abort_at : len;
      exp_crc_in  = crc16_of(exp_bits, nbits);
      exp_crc_out = crc16_of(old_bits, nbits);
      en_cnt = 0; fetch_cnt = 0; hs_cnt = 0; head_err = 0; bubble_err = 0;
      last_en_cyc = -1; done_cyc = -1; timed_out = 1'b1; aborted = 1'b0; fed = 0;
      @(negedge clk);
      start = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (cyc = 0; cyc < 400; cyc++) begin
         valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         data  = (fed == 0) ? w0 : (fed == 1) ? w1 : $urandom;
         if (abort_at >= 0 && en_cnt == abort_at) abort = 1'b1;
         #1;
         if (abort) begin
            abort_en = en;
            aborted  = 1'b1;
            break;
         end
         if (en) begin
            if (en_cnt >= len || head !== exp_bits[en_cnt]) head_err++;
            en_cnt++;
            last_en_cyc = cyc;
         end
         if (ready) fetch_cnt++;
         if (busy && (ready == en)) bubble_err++;
         if (valid && ready) begin
            hs_cnt++;
            fed++;
         end
         if (done && done_cyc < 0) done_cyc = cyc;
         if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
      if (aborted) begin
         timed_out = 1'b0;
         @(negedge clk);
         abort = 1'b0;
         valid = 1'b0;
         #1;
         post_busy  = busy;
         post_done  = done;
         post_ready = ready;
      end
      valid = 1'b0;
   endtask

   logic [31:0] w0, w1, rw0, rw1;
   logic [15:0] p1_crc, frozen_in, frozen_out;
   logic [39:0] exp_chain_b;

   initial begin
      w0 = 32'hA5A5_0F0F;
      w1 = 32'h1234_5678;

      repeat (2) @(negedge clk);
      #1;
      check("reset_head",   64'(head_a), 64'(0));
      check("reset_clk_en", 64'(en_a),   64'(0));
      check("reset_busy",   64'(busy_a), 64'(0));
      check("reset_done",   64'(done_a), 64'(0));
      check("reset_ready",  64'(ready_a), 64'(0));
      check("reset_crc_in", 64'(crcin_a), 64'(16'hFFFF));
      check("reset_crc_out", 64'(crcout_a), 64'(16'hFFFF));
      @(negedge clk);
      rst_n = 1'b1;

      // pass 1 on a zeroed 64-bit chain
      run_pass(w0, w1, 1'b0, -1);
      check("p1_timeout",   64'(timed_out), 64'(0));
      check("p1_clk_en",    64'(en_cnt), 64'(64));
      check("p1_fetch_gaps", 64'(fetch_cnt), 64'(2));
      check("p1_handshakes", 64'(hs_cnt), 64'(2));
      check("p1_head_bits", 64'(head_err), 64'(0));
      check("p1_bubbles",   64'(bubble_err), 64'(0));
      check("p1_done_lat",  64'(done_cyc - last_en_cyc), 64'(1));
      check("p1_done",      64'(done_a), 64'(1));
      check("p1_busy",      64'(busy_a), 64'(0));
      check("p1_chain",     chain_a, {w1, w0});
      check("p1_crc_in",    64'(crcin_a), 64'(exp_crc_in));
      check("p1_crc_out",   64'(crcout_a), 64'(exp_crc_out));
      p1_crc = exp_crc_in;

      // pass 2: returned bits are pass-1 bits
      run_pass(w0, w1, 1'b0, -1);
      check("p2_clk_en",   64'(en_cnt), 64'(64));
      check("p2_crc_out",  64'(crcout_a), 64'(p1_crc));
      check("p2_crc_in",   64'(crcin_a), 64'(p1_crc));
      check("p2_chain",    chain_a, {w1, w0});

      // 40-bit chain: partial second word
      sel = 1'b1;
      run_pass(w0, w1, 1'b0, -1);
      exp_chain_b = {w1[7:0], w0};
      check("c40_timeout",   64'(timed_out), 64'(0));
      check("c40_clk_en",    64'(en_cnt), 64'(40));
      check("c40_handshakes", 64'(hs_cnt), 64'(2));
      check("c40_head_bits", 64'(head_err), 64'(0));
      check("c40_done",      64'(done_b), 64'(1));
      check("c40_chain",     64'(chain_b), 64'(exp_chain_b));
      check("c40_crc_in",    64'(crcin_b), 64'(exp_crc_in));
      check("c40_crc_out",   64'(crcout_b), 64'(exp_crc_out));
      sel = 1'b0;

      // throttled valid
      run_pass(w0, w1, 1'b1, -1);
      check("thr_timeout",  64'(timed_out), 64'(0));
      check("thr_clk_en",   64'(en_cnt), 64'(64));
      check("thr_bubbles",  64'(bubble_err), 64'(0));
      check("thr_head_bits", 64'(head_err), 64'(0));
      check("thr_chain",    chain_a, {w1, w0});
      check("thr_crc_out",  64'(crcout_a), 64'(p1_crc));

      // random words
      rw0 = $urandom;
      rw1 = $urandom;
      run_pass(rw0, rw1, 1'b1, -1);
      check("rnd_clk_en",  64'(en_cnt), 64'(64));
      check("rnd_chain",   chain_a, {rw1, rw0});
      check("rnd_crc_in",  64'(crcin_a), 64'(exp_crc_in));
      check("rnd_crc_out", 64'(crcout_a), 64'(exp_crc_out));

      // abort after 17 shift cycles
      run_pass(w0, w1, 1'b0, 17);
      check("abt_clk_en_gate", 64'(abort_en), 64'(0));
      check("abt_shifts",  64'(en_cnt), 64'(17));
      check("abt_busy",    64'(post_busy), 64'(0));
      check("abt_done",    64'(post_done), 64'(0));
      check("abt_ready",   64'(post_ready), 64'(0));
      check("abt_crc_in",  64'(crcin_a), 64'(exp_crc_in));
      check("abt_crc_out", 64'(crcout_a), 64'(exp_crc_out));
      frozen_in  = exp_crc_in;
      frozen_out = exp_crc_out;
      repeat (3) @(negedge clk);
      #1;
      check("abt_crc_in_frozen",  64'(crcin_a), 64'(frozen_in));
      check("abt_crc_out_frozen", 64'(crcout_a), 64'(frozen_out));
      check("abt_idle_clk_en",    64'(en_a), 64'(0));

      // reset mid-SHIFT
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      valid = 1'b1;
      data  = rw0;
      repeat (10) @(negedge clk);
      #1;
      check("rst_pre_clk_en", 64'(en_a), 64'(1));
      rst_n = 1'b0;
      #1;
      check("rst_clk_en",  64'(en_a), 64'(0));
      check("rst_head",    64'(head_a), 64'(0));
      check("rst_busy",    64'(busy_a), 64'(0));
      check("rst_ready",   64'(ready_a), 64'(0));
      check("rst_crc_in",  64'(crcin_a), 64'(16'hFFFF));
      check("rst_crc_out", 64'(crcout_a), 64'(16'hFFFF));
      valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      run_pass(w0, w1, 1'b0, -1);
      check("fresh_timeout", 64'(timed_out), 64'(0));
      check("fresh_clk_en",  64'(en_cnt), 64'(64));
      check("fresh_chain",   chain_a, {w1, w0});
      check("fresh_crc_in",  64'(crcin_a), 64'(p1_crc));
      check("fresh_crc_out", 64'(crcout_a), 64'(exp_crc_out));
      check("fresh_done",    64'(done_a), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
